// File: rtl/uart_rx_os.sv
// UART receiver: 16x oversampled, majority-voted 8N1 (or 8E1) byte receiver.
// Latency: byte reported one clk after the stop-bit mid-point (tick 9 of the stop cell).
// Backpressure: none on the line; an unacknowledged byte is overwritten and flagged by overrun.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   sel[1:0]   baud select (00=9600, 01=19200, 10=57600, 11=115200), latched at start detection
//   rx         asynchronous serial input, idles high
//   rx_ack     consumer acknowledge; clears rx_valid and overrun
//   rx_data    last accepted byte
//   rx_valid   high while rx_data holds an unacknowledged byte
//   rx_done    one-clk pulse per accepted byte
//   frame_err  one-clk pulse when the stop bit samples low
//   parity_err one-clk pulse on even-parity mismatch (tied 0 without parity)
//   overrun    sticky; a byte was accepted while rx_valid was high
//
// Build option: define UART_RX_PARITY_EN for 8E1 frames (even parity checked);
// default build receives 8N1 frames.
module uart_rx_os #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_done,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int DIV_9600   = CLK_FREQ / (9600 * 16);
    localparam int DIV_19200  = CLK_FREQ / (19200 * 16);
    localparam int DIV_57600  = CLK_FREQ / (57600 * 16);
    localparam int DIV_115200 = CLK_FREQ / (115200 * 16);
    localparam int DW         = (DIV_9600 > 1) ? $clog2(DIV_9600 + 1) : 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    sel_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] baud_cnt;
    logic [4:0]    tick_cnt;
    logic [4:0]    tick_adv;
    logic          tick;
    logic          samp7, samp8;
    logic          maj;
    logic          s_tick9;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt;
    logic          start_det;
    logic          accept;
    logic          ferr_d;
    logic          perr_d;
`ifdef UART_RX_PARITY_EN
    logic          par_err_q;
`endif

    // Divisor follows the latched select so a mid-frame sel change cannot
    // stretch or shrink the cells of the frame in flight.
    always_comb begin
        div_q = DW'(DIV_9600);
        case (sel_q)
            2'b00:   div_q = DW'(DIV_9600);
            2'b01:   div_q = DW'(DIV_19200);
            2'b10:   div_q = DW'(DIV_57600);
            default: div_q = DW'(DIV_115200);
        endcase
    end

    assign tick = (state_q != IDLE) && (baud_cnt == div_q - DW'(1));

    // tick_cnt counts ticks since start detection. Bit 4 clear means we are
    // still inside the start cell (0..15); once it reaches 16 it stays in
    // 16..31 and its low nibble is the position inside the current bit cell.
    // This keeps the tail of the start cell (after the tick-8 check) from
    // being mistaken for data-cell sample points.
    assign tick_adv = (tick_cnt == 5'd31) ? 5'd16 : tick_cnt + 5'd1;
    assign s_tick9  = tick && tick_adv[4] && (tick_adv[3:0] == 4'd9);
    assign maj      = (samp7 & samp8) | (samp7 & rx_sync) | (samp8 & rx_sync);

    always_comb begin
        state_d   = state_q;
        start_det = 1'b0;
        accept    = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_prev && !rx_sync) begin
                    start_det = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (tick && tick_adv == 5'd8) begin
                    state_d = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (s_tick9 && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick9) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (s_tick9) begin
                    state_d = IDLE;
                    if (!maj) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_err_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            sel_q      <= 2'b00;
            baud_cnt   <= '0;
            tick_cnt   <= '0;
            samp7      <= 1'b1;
            samp8      <= 1'b1;
            shift_q    <= 8'h00;
            bit_cnt    <= 3'd0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_done    <= accept;
            frame_err  <= ferr_d;
            parity_err <= perr_d;

            if (start_det) begin
                sel_q    <= sel;
                baud_cnt <= '0;
                tick_cnt <= '0;
                bit_cnt  <= 3'd0;
`ifdef UART_RX_PARITY_EN
                par_err_q <= 1'b0;
`endif
            end else if (state_q != IDLE) begin
                if (tick) begin
                    baud_cnt <= '0;
                    tick_cnt <= tick_adv;
                end else begin
                    baud_cnt <= baud_cnt + DW'(1);
                end
            end

            if (tick && tick_adv[4] && tick_adv[3:0] == 4'd7) samp7 <= rx_sync;
            if (tick && tick_adv[4] && tick_adv[3:0] == 4'd8) samp8 <= rx_sync;

            if (s_tick9 && state_q == DATA) begin
                shift_q <= {maj, shift_q[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (s_tick9 && state_q == PARITY) begin
                par_err_q <= maj ^ (^shift_q);
            end
`endif

            if (accept) begin
                rx_data <= shift_q;
            end

            // Acceptance wins over acknowledge so a byte arriving in the ack
            // cycle is not lost; it only counts as an overrun if the old byte
            // was still pending and not being acknowledged.
            if (accept) begin
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            if (accept && rx_valid && !rx_ack) begin
                overrun <= 1'b1;
            end else if (rx_ack && rx_valid) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter: CLK_FREQ, 50000000, system clock frequency in Hz.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: sel  input  2  baud select: 00=9600, 01=19200, 10=57600, 11=115200.
REQ-005 Port: rx  input  1  asynchronous serial line; idles high.
REQ-006 Port: rx_ack  input  1  consumer acknowledge; clears rx_valid and overrun.
REQ-007 Port: rx_data  output  8  last accepted byte.
REQ-008 Port: rx_valid  output  1  level; high while rx_data holds an unacknowledged byte.
REQ-009 Port: rx_done  output  1  one-clk pulse per accepted byte.
REQ-010 Port: frame_err  output  1  one-clk pulse when the stop bit samples low.
REQ-011 Port: parity_err  output  1  one-clk pulse on even-parity mismatch.
REQ-012 Port: overrun  output  1  sticky; a byte was accepted while rx_valid was high.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-014 A 16x oversample tick SHALL be generated every CLK_FREQ/(baud*16) clocks (integer truncation); at 50 MHz: 325, 162, 54, 27.
REQ-015 sel SHALL be latched on start detection; sel changes mid-frame SHALL be ignored until the next frame.
REQ-016 States SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-017 IDLE->START on a 1->0 transition of synchronized rx; tick counter cleared.
REQ-018 START: at tick 8, rx high -> IDLE (false start, no outputs); rx low -> DATA.
REQ-019 Each bit value SHALL be the majority of samples at ticks 7, 8, 9 of its 16-tick bit cell.
REQ-020 DATA SHALL shift 8 bits LSB first, then go to PARITY (macro) or STOP.
REQ-021 STOP: at the stop-bit mid-point the FSM SHALL return to IDLE.
REQ-022 Stop bit 1 and no parity error: rx_data loaded, rx_valid set, rx_done pulsed.
REQ-023 Stop bit 0: frame_err pulsed; rx_data, rx_valid and rx_done unchanged.
REQ-024 Parity error with valid stop: parity_err pulsed; byte discarded as in REQ-023.
REQ-025 Byte accepted while rx_valid=1 and rx_ack=0: rx_data overwritten, overrun set.
REQ-026 Byte acceptance and rx_ack in the same cycle: new data loaded, rx_valid stays 1, overrun not set.
REQ-027 rx_ack with rx_valid=0 SHALL have no effect.
REQ-028 Line held low (break) SHALL yield one frame_err, then IDLE waits for a new 1->0 edge.
REQ-029 Back-to-back frames with no idle gap beyond the stop bit SHALL be received without loss.

Reset
REQ-030 reset low SHALL asynchronously force IDLE and clear all counters and the shift register.
REQ-031 Reset SHALL set both synchronizer flops to 1.
REQ-032 Reset SHALL set rx_data=8'h00 and rx_valid, rx_done, frame_err, parity_err, overrun=0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no output pulse.

Configuration
REQ-034 Macro UART_RX_PARITY_EN defined: frame is 8E1; PARITY state checks even parity over the 8 data bits.
REQ-035 Macro undefined: frame is 8N1; PARITY state absent; parity_err tied 0.

Verification
REQ-036 sel=11, frame 0xA5 (8N1) -> rx_data=0xA5, rx_valid=1, one rx_done pulse.
REQ-037 sel=00, 3-tick low glitch on idle rx -> no rx_done, no frame_err, FSM back in IDLE.
REQ-038 sel=10, 0x3C with stop bit forced 0 -> one frame_err pulse, rx_valid stays 0.
REQ-039 Frames 0x11 then 0x22 back-to-back, no rx_ack -> rx_data=0x22, overrun=1; rx_ack -> rx_valid=0, overrun=0.
REQ-040 Reset pulsed at data bit 4 of 0xFF, then 0x5A sent -> only 0x5A received.
REQ-041 UART_RX_PARITY_EN, 0x07 with parity bit 0 -> one parity_err pulse, rx_valid stays 0.
